fsm_stim_sequencer: RTL and testbench

Scripted stimulus controller for the 3-bit, 2-input Mealy/Moore state-machine block and its three implementation variants: memory-based, case-based and gate-level. It holds a small program of (input code, hold count) entries. On `start` it resets the three FSM instances, then plays the program onto their shared `a` input. Every run cycle it compares the three `s` outputs in lockstep and reports a sticky mismatch with the failing step index.

---
 rtl/fsm_stim_sequencer_pkg.sv | 27 ++
 rtl/fsm_stim_sequencer_if.sv | 37 +++
 rtl/fsm_stim_sequencer_compare.sv | 15 +
 rtl/fsm_stim_sequencer.sv | 157 +++++++++++++++
 tb/tb_fsm_stim_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fsm_stim_sequencer_pkg.sv
// Shared definitions for the FSM stimulus sequencer: sequencer state encoding,
// widths of the FSM-under-test buses and the program word field layout.
package fsm_stim_sequencer_pkg;

  localparam int A_W = 2;
  localparam int S_W = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FRST = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_FRST = FRST,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_e;

  // Program word is {a_code, hold_count}; the hold field sits at the bottom.
  localparam int HOLD_LSB = 0;

  function automatic int a_lsb(input int cnt_w);
    return HOLD_LSB + cnt_w;
  endfunction

endpackage

// File: rtl/fsm_stim_sequencer_if.sv
// Bus between the stimulus sequencer (slave side) and whoever programs it and
// hosts the three FSM variants (master side).
interface fsm_stim_sequencer_if
  import fsm_stim_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                  prog_we;
  logic [ADDR_W-1:0]     prog_addr;
  logic [A_W+CNT_W-1:0]  prog_data;
  logic [ADDR_W:0]       len;
  logic                  start;
  logic [S_W-1:0]        s_mem;
  logic [S_W-1:0]        s_case;
  logic [S_W-1:0]        s_gate;
  logic [A_W-1:0]        a_out;
  logic                  fsm_rst_n;
  logic                  busy;
  logic                  done;
  logic                  mismatch;
  logic [7:0]            mismatch_step;
  logic [S_W-1:0]        last_s;

  modport master (
    output prog_we, prog_addr, prog_data, len, start, s_mem, s_case, s_gate,
    input  a_out, fsm_rst_n, busy, done, mismatch, mismatch_step, last_s
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, len, start, s_mem, s_case, s_gate,
    output a_out, fsm_rst_n, busy, done, mismatch, mismatch_step, last_s
  );

endinterface

// File: rtl/fsm_stim_sequencer_compare.sv
// Lockstep equality of three equally wide buses.
module triple_compare
  import fsm_stim_sequencer_pkg::*;
#(
  parameter int W = S_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         eq
);

  assign eq = (a == b) && (b == c);

endmodule

// File: rtl/fsm_stim_sequencer.sv
// Plays a stored (a_code, hold) program onto three FSM variants after resetting
// them, and flags the first run cycle where their outputs disagree.
module fsm_stim_sequencer
  import fsm_stim_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input logic                 clk,
  input logic                 rst,
  fsm_stim_sequencer_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int LEN_W  = ADDR_W + 1;
  localparam int PROG_W = A_W + CNT_W;
  localparam int A_LSB  = a_lsb(CNT_W);

  state_e              state_q, state_d;
  logic [PROG_W-1:0]   mem_q [DEPTH];
  logic [PROG_W-1:0]   mem_d [DEPTH];
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic [7:0]          step_q, step_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mismatch_q, mismatch_d;
  logic [7:0]          mismatch_step_q, mismatch_step_d;
  logic [S_W-1:0]      last_s_q, last_s_d;

  logic [PROG_W-1:0]   cur_entry;
  logic [A_W-1:0]      cur_a;
  logic [CNT_W-1:0]    cur_hold;
  logic                hold_done;
  logic                last_entry;
  logic                cmp_en;
  logic                s_eq;

  assign cur_entry  = mem_q[ptr_q];
  assign cur_a      = cur_entry[A_LSB +: A_W];
  assign cur_hold   = cur_entry[HOLD_LSB +: CNT_W];
  assign hold_done  = (hold_q == cur_hold);
  assign last_entry = ({1'b0, ptr_q} == (len_q - LEN_W'(1)));

  // The first RUN cycle still shows the freshly reset FSMs, so it is skipped.
  assign cmp_en = ((state_q == ST_RUN) && (step_q != 8'd0)) || (state_q == ST_DONE);

  triple_compare #(.W(S_W)) u_cmp (
    .a  (bus.s_mem),
    .b  (bus.s_case),
    .c  (bus.s_gate),
    .eq (s_eq)
  );

  always_comb begin
    state_d         = state_q;
    mem_d           = mem_q;
    len_d           = len_q;
    ptr_d           = ptr_q;
    hold_d          = hold_q;
    step_d          = step_q;
    mismatch_d      = mismatch_q;
    mismatch_step_d = mismatch_step_q;
    last_s_d        = last_s_q;

    if (bus.prog_we && (state_q == ST_IDLE)) begin
      mem_d[bus.prog_addr] = bus.prog_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d         = ST_FRST;
          len_d           = bus.len;
          ptr_d           = '0;
          hold_d          = '0;
          step_d          = '0;
          mismatch_d      = 1'b0;
          mismatch_step_d = '0;
          last_s_d        = '0;
        end
      end
      ST_FRST: begin
        state_d = (len_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        step_d = (step_q == 8'hFF) ? step_q : step_q + 8'd1;
        if (hold_done) begin
          hold_d = '0;
          if (last_entry) begin
            state_d = ST_DONE;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (cmp_en) begin
      last_s_d = bus.s_case;
      if (!s_eq && !mismatch_q) begin
        mismatch_d      = 1'b1;
        mismatch_step_d = step_q;
      end
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      mem_q           <= '{default: '0};
      len_q           <= '0;
      ptr_q           <= '0;
      hold_q          <= '0;
      step_q          <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      mismatch_q      <= 1'b0;
      mismatch_step_q <= '0;
      last_s_q        <= '0;
    end else begin
      state_q         <= state_d;
      mem_q           <= mem_d;
      len_q           <= len_d;
      ptr_q           <= ptr_d;
      hold_q          <= hold_d;
      step_q          <= step_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      mismatch_q      <= mismatch_d;
      mismatch_step_q <= mismatch_step_d;
      last_s_q        <= last_s_d;
    end
  end

  // rst is folded in so the FSM variants are held in reset alongside us.
  assign bus.fsm_rst_n     = rst && (state_q != ST_FRST);
  assign bus.a_out         = (state_q == ST_RUN) ? cur_a : '0;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.mismatch      = mismatch_q;
  assign bus.mismatch_step = mismatch_step_q;
  assign bus.last_s        = last_s_q;

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// Bench for fsm_stim_sequencer: hosts a stand-in FSM for all three variants,
// replays directed and random programs and checks against a program-level model.
module tb_fsm_stim_sequencer;
  import fsm_stim_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fsm_stim_sequencer_if bus ();

  fsm_stim_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int model_a [8];
  int model_h [8];

  logic [2:0] fsm_s;
  logic       gate_force;

  // Stand-in FSM: counts 0,1,2 on a=0, otherwise steps by a (mod 8).
  function automatic logic [2:0] fsm_next(input logic [2:0] s, input logic [1:0] a);
    if (a == 2'd0) return (s >= 3'd2) ? 3'd0 : s + 3'd1;
    return s + {1'b0, a};
  endfunction

  always @(posedge clk) begin
    if (!bus.fsm_rst_n) fsm_s <= 3'd0;
    else                fsm_s <= fsm_next(fsm_s, bus.a_out);
  end

  assign bus.s_mem  = fsm_s;
  assign bus.s_case = fsm_s;
  assign bus.s_gate = gate_force ? 3'd7 : fsm_s;

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic writeEntry(input int addr, input int a, input int h);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = 3'(addr);
    bus.prog_data = {2'(a), 4'(h)};
    model_a[addr] = a;
    model_h[addr] = h;
    @(negedge clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, "_busy"},  bus.busy, 0);
    checkOutput({phase, "_done"},  bus.done, 0);
    checkOutput({phase, "_a"},     bus.a_out, 0);
    checkOutput({phase, "_rst_n"}, bus.fsm_rst_n, 0);
    checkOutput({phase, "_mm"},    bus.mismatch, 0);
    checkOutput({phase, "_step"},  bus.mismatch_step, 0);
    checkOutput({phase, "_last"},  bus.last_s, 0);
  endtask

  // One complete run; optional gate fault, busy-time injection, reset, and write-with-start.
  task automatic applyStimulus(input int nlen, input int force_cyc, input bit inject,
                               input int rst_cyc, input bit sw, input int sw_a, input int sw_h);
    logic [1:0] exp_a [$];
    logic [2:0] exp_last;
    int         n;
    bit         exp_mm;
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 4'(nlen);
    if (sw) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 3'd0;
      bus.prog_data = {2'(sw_a), 4'(sw_h)};
      model_a[0]    = sw_a;
      model_h[0]    = sw_h;
    end
    for (int e = 0; e < nlen; e++)
      for (int r = 0; r <= model_h[e]; r++) exp_a.push_back(2'(model_a[e]));
    exp_last = 3'd0;
    foreach (exp_a[i]) exp_last = fsm_next(exp_last, exp_a[i]);
    n      = exp_a.size();
    exp_mm = (force_cyc >= 1) && (force_cyc < n);

    @(negedge clk);
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    checkOutput("frst_busy",  bus.busy, 1);
    checkOutput("frst_rst_n", bus.fsm_rst_n, 0);
    checkOutput("frst_a",     bus.a_out, 0);
    checkOutput("frst_done",  bus.done, 0);
    checkOutput("frst_mm",    bus.mismatch, 0);

    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      gate_force  = 1'b0;
      checkOutput("run_a",     bus.a_out, exp_a[j]);
      checkOutput("run_busy",  bus.busy, 1);
      checkOutput("run_rst_n", bus.fsm_rst_n, 1);
      checkOutput("run_done",  bus.done, 0);
      checkOutput("run_mm",    bus.mismatch, (force_cyc >= 1 && force_cyc <= j - 1) ? 1 : 0);
      if (j == force_cyc) gate_force = 1'b1;
      if (inject && j == 0) begin
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd0;
        bus.prog_data = 6'h3F;
      end
      if (j == rst_cyc) begin
        gate_force = 1'b0;
        rst = 1'b0;
        #1;
        checkResetValues("async_rst");
        for (int i = 0; i < 8; i++) begin
          model_a[i] = 0;
          model_h[i] = 0;
        end
        @(negedge clk);
        rst = 1'b1;
        checkOutput("post_rst_done", bus.done, 0);
        @(negedge clk);
        checkOutput("post_rst_done2", bus.done, 0);
        checkOutput("post_rst_busy",  bus.busy, 0);
        checkOutput("post_rst_rst_n", bus.fsm_rst_n, 1);
        return;
      end
    end

    @(negedge clk);
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    gate_force  = 1'b0;
    checkOutput("done_pulse", bus.done, 1);
    checkOutput("done_busy",  bus.busy, 1);
    checkOutput("done_a",     bus.a_out, 0);
    checkOutput("done_rst_n", bus.fsm_rst_n, 1);
    checkOutput("done_mm",    bus.mismatch, exp_mm);
    checkOutput("done_step",  bus.mismatch_step, exp_mm ? force_cyc : 0);

    @(negedge clk);
    checkOutput("idle_done",  bus.done, 0);
    checkOutput("idle_busy",  bus.busy, 0);
    checkOutput("idle_a",     bus.a_out, 0);
    checkOutput("idle_mm",    bus.mismatch, exp_mm);
    checkOutput("idle_step",  bus.mismatch_step, exp_mm ? force_cyc : 0);
    checkOutput("idle_last",  bus.last_s, exp_last);
  endtask

  initial begin
    int nlen;
    int n;
    int fc;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.len       = '0;
    bus.start     = 1'b0;
    gate_force    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      model_a[i] = 0;
      model_h[i] = 0;
    end

    #2 rst = 1'b0;
    #1 checkResetValues("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("idle_rst_n", bus.fsm_rst_n, 1);
    checkOutput("idle0_busy", bus.busy, 0);

    $display("[TB] single entry a=0 hold=2");
    writeEntry(0, 0, 2);
    applyStimulus(1, -1, 1'b0, -1, 1'b0, 0, 0);

    $display("[TB] three entry program");
    writeEntry(0, 1, 0);
    writeEntry(1, 2, 1);
    writeEntry(2, 3, 2);
    applyStimulus(3, -1, 1'b0, -1, 1'b0, 0, 0);

    $display("[TB] gate fault on run cycle 3");
    applyStimulus(3, 3, 1'b0, -1, 1'b0, 0, 0);

    $display("[TB] empty program");
    applyStimulus(0, -1, 1'b0, -1, 1'b0, 0, 0);

    $display("[TB] start and write while busy");
    applyStimulus(3, -1, 1'b1, -1, 1'b0, 0, 0);
    applyStimulus(3, -1, 1'b0, -1, 1'b0, 0, 0);

    $display("[TB] write together with start");
    applyStimulus(1, -1, 1'b0, -1, 1'b1, 2, 1);

    $display("[TB] random programs");
    for (int it = 0; it < 6; it++) begin
      for (int e = 0; e < 8; e++) writeEntry(e, int'($urandom_range(3, 0)), int'($urandom_range(15, 0)));
      nlen = int'($urandom_range(8, 0));
      n = 0;
      for (int e = 0; e < nlen; e++) n += model_h[e] + 1;
      fc = -1;
      if (n >= 2 && $urandom_range(1, 0) == 1) fc = int'($urandom_range(n - 1, 1));
      applyStimulus(nlen, fc, 1'b0, -1, 1'b0, 0, 0);
    end

    $display("[TB] reset in the middle of a run");
    writeEntry(0, 1, 0);
    writeEntry(1, 2, 1);
    writeEntry(2, 3, 2);
    applyStimulus(3, 1, 1'b0, 4, 1'b0, 0, 0);
    applyStimulus(1, -1, 1'b0, -1, 1'b0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
